// File: rtl/tlc_seq_pkg.sv
// Shared state encoding and sizing helpers for the tlc_seq sequencing controller.
package tlc_seq_pkg;

   localparam logic [1:0] STATE_IDLE_ENC  = 2'd0;
   localparam logic [1:0] STATE_RUN_ENC   = 2'd1;
   localparam logic [1:0] STATE_CLEAR_ENC = 2'd2;

   localparam int unsigned EXT_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = STATE_IDLE_ENC,
      ST_RUN   = STATE_RUN_ENC,
      ST_CLEAR = STATE_CLEAR_ENC
   } tlc_state_e;

   // Phase index width: max(1, clog2(n)).
   function automatic int unsigned ph_width(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tlc_seq_timer.sv
// Loadable down-counter that saturates at zero, with hold and a registered zero flag.
module tlc_seq_timer
   import tlc_seq_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             CK,
   input  logic             RN,
   input  logic             load_i,
   input  logic             hold_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             zero_q;

   // Load wins over hold so a clear can always reset the count.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (!hold_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= (cnt_d == '0);
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = zero_q;

endmodule

// File: rtl/tlc_seq_ctrl.sv
// Multi-phase sequencing controller with clearance gaps.
// Define TLC_SEQ_EXTEND_EN to let req_i extend phase 0 up to MAX_EXT times.
module tlc_seq_ctrl
   import tlc_seq_pkg::*;
#(
   parameter int unsigned NUM_PH  = 4,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned PH_LEN  = 16,
   parameter int unsigned GAP_LEN = 2,
   parameter int unsigned EXT_LEN = 8,
   parameter int unsigned MAX_EXT = 2,
   localparam int unsigned PH_W   = ph_width(NUM_PH)
) (
   input  logic              CK,
   input  logic              RN,
   input  logic              clr_i,
   input  logic              req_i,
   input  logic              hold_i,
   output logic [PH_W-1:0]   phase_o,
   output logic [NUM_PH-1:0] lamp_o,
   output logic [CNT_W-1:0]  timer_o,
   output logic [1:0]        state_o,
   output logic              done_o,
   output logic              wrap_o,
   output logic              ext_o
);

   localparam logic [CNT_W-1:0] PH_LD  = CNT_W'(PH_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LD = CNT_W'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
`ifdef TLC_SEQ_EXTEND_EN
   localparam logic [CNT_W-1:0] EXT_LD = CNT_W'(EXT_LEN - 1);
`endif

   tlc_state_e        state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [NUM_PH-1:0] lamp_q, lamp_d;
   logic              done_q, done_d;
   logic              wrap_q, wrap_d;
   logic              adv_c;
   logic              tmr_load_c;
   logic [CNT_W-1:0]  tmr_val_c;
   logic [CNT_W-1:0]  tmr_cnt;
   logic              tmr_zero;

`ifdef TLC_SEQ_EXTEND_EN
   logic [EXT_CNT_W-1:0] ext_cnt_q, ext_cnt_d;
   logic                 ext_q, ext_d;
   logic                 ext_take_c;

   assign ext_take_c = (phase_q == '0) && req_i && (ext_cnt_q < EXT_CNT_W'(MAX_EXT));
`endif

   tlc_seq_timer #(.CNT_W(CNT_W)) u_timer (
      .CK         (CK),
      .RN         (RN),
      .load_i     (tmr_load_c),
      .hold_i     (hold_i),
      .load_val_i (tmr_val_c),
      .cnt_o      (tmr_cnt),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      done_d     = 1'b0;
      wrap_d     = 1'b0;
      adv_c      = 1'b0;
      tmr_load_c = 1'b0;
      tmr_val_c  = '0;
`ifdef TLC_SEQ_EXTEND_EN
      ext_cnt_d  = ext_cnt_q;
      ext_d      = ext_q;
`endif
      if (clr_i) begin
         state_d    = ST_IDLE;
         phase_d    = '0;
         tmr_load_c = 1'b1;
`ifdef TLC_SEQ_EXTEND_EN
         ext_cnt_d  = '0;
         ext_d      = 1'b0;
`endif
      end else if (!hold_i) begin
         case (state_q)
            ST_IDLE: begin
               if (req_i) begin
                  state_d    = ST_RUN;
                  phase_d    = '0;
                  tmr_load_c = 1'b1;
                  tmr_val_c  = PH_LD;
               end
            end
            ST_RUN: begin
               if (tmr_zero) begin
`ifdef TLC_SEQ_EXTEND_EN
                  if (ext_take_c) begin
                     tmr_load_c = 1'b1;
                     tmr_val_c  = EXT_LD;
                     ext_cnt_d  = ext_cnt_q + EXT_CNT_W'(1);
                     ext_d      = 1'b1;
                  end else
`endif
                  begin
                     done_d = 1'b1;
                     if (GAP_LEN > 0) begin
                        state_d    = ST_CLEAR;
                        tmr_load_c = 1'b1;
                        tmr_val_c  = GAP_LD;
                     end else begin
                        adv_c = 1'b1;
                     end
                  end
               end
            end
            ST_CLEAR: begin
               if (tmr_zero) adv_c = 1'b1;
            end
            default: begin
               state_d    = ST_IDLE;
               phase_d    = '0;
               tmr_load_c = 1'b1;
`ifdef TLC_SEQ_EXTEND_EN
               ext_cnt_d  = '0;
               ext_d      = 1'b0;
`endif
            end
         endcase
         // Phase advance shared by the gap-less RUN path and the end of CLEAR.
         if (adv_c) begin
            state_d    = ST_RUN;
            wrap_d     = (phase_q == PH_W'(NUM_PH - 1));
            phase_d    = wrap_d ? '0 : (phase_q + PH_W'(1));
            tmr_load_c = 1'b1;
            tmr_val_c  = PH_LD;
`ifdef TLC_SEQ_EXTEND_EN
            ext_cnt_d  = '0;
            ext_d      = 1'b0;
`endif
         end
      end
      lamp_d = (state_d == ST_RUN) ? (NUM_PH'(1) << phase_d) : '0;
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         lamp_q  <= '0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         lamp_q  <= lamp_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end

`ifdef TLC_SEQ_EXTEND_EN
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         ext_cnt_q <= '0;
         ext_q     <= 1'b0;
      end else begin
         ext_cnt_q <= ext_cnt_d;
         ext_q     <= ext_d;
      end
   end

   assign ext_o = ext_q;
`else
   assign ext_o = 1'b0;
`endif

   assign phase_o = phase_q;
   assign lamp_o  = lamp_q;
   assign timer_o = tmr_cnt;
   assign state_o = state_q;
   assign done_o  = done_q;
   assign wrap_o  = wrap_q;

endmodule
